// File: rtl/qkv_pkg.sv
// Shared definitions for the QKV requantization cache: width helpers, FSM states, saturation limits.
package qkv_pkg;

  localparam int N_DEFAULT       = 768;
  localparam int DW_DEFAULT      = 4;
  localparam int SEQ_LEN_DEFAULT = 64;

  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int idx_width(input int seq_len);
    return $clog2(seq_len);
  endfunction

  localparam int AW_DEFAULT = acc_width(N_DEFAULT, DW_DEFAULT);
  localparam int IW_DEFAULT = idx_width(SEQ_LEN_DEFAULT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUANT,
    S_STORE,
    S_HOLDQ
  } state_t;

  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/requant_lane.sv
// Single-element requantizer: arithmetic right shift, then saturation to a DW-bit signed range.
// Define REQUANT_ROUND_EN to round half up before the shift instead of truncating.
module requant_lane
  import qkv_pkg::*;
#(
  parameter int AW = 18,
  parameter int DW = 4
) (
  input  logic [AW-1:0] acc,
  input  logic [4:0]    shift,
  output logic [DW-1:0] q
);

  localparam logic signed [AW:0] HI = (AW + 1)'(sat_max(DW));
  localparam logic signed [AW:0] LO = (AW + 1)'(sat_min(DW));

  logic signed [AW:0] ext;
  logic signed [AW:0] t;

  assign ext = {acc[AW-1], acc};

`ifdef REQUANT_ROUND_EN
  logic signed [AW:0] half;
  logic signed [AW:0] biased;
  logic        [4:0]  shift_m1;

  assign shift_m1 = shift - 5'd1;

  always_comb begin
    half = '0;
    if (shift != 5'd0 && int'(shift) <= AW) half = (AW + 1)'(1) << shift_m1;
  end

  assign biased = ext + half;
  // Past AW bits of shift, the rounded quotient of any in-range accumulator is exactly zero.
  assign t = (int'(shift) > AW) ? '0 : (biased >>> shift);
`else
  assign t = ext >>> shift;
`endif

  always_comb begin
    if (t > HI)      q = DW'(HI);
    else if (t < LO) q = DW'(LO);
    else             q = t[DW-1:0];
  end

endmodule

// File: rtl/qkv_requant_cache.sv
// Requantizes one token's Q/K/V accumulators, caches K/V per token and forwards Q with valid/ready.
// Rounding mode selected by REQUANT_ROUND_EN (see requant_lane); default build truncates.
module qkv_requant_cache
  import qkv_pkg::*;
#(
  parameter  int N       = 768,
  parameter  int DW      = 4,
  parameter  int PE_NUM  = 12,
  parameter  int SEQ_LEN = 64,
  localparam int AW      = acc_width(N, DW),
  localparam int IW      = idx_width(SEQ_LEN)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [4:0]                     cfg_shift,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [PE_NUM-1:0][AW-1:0]      acc_q,
  input  logic [PE_NUM-1:0][AW-1:0]      acc_k,
  input  logic [PE_NUM-1:0][AW-1:0]      acc_v,
  output logic                           q_valid,
  input  logic                           q_ready,
  output logic [PE_NUM-1:0][DW-1:0]      q_out,
  output logic [IW:0]                    tok_count,
  output logic                           full,
  input  logic                           rd_en,
  input  logic [IW-1:0]                  rd_idx,
  output logic                           rd_valid,
  output logic                           rd_err,
  output logic [PE_NUM-1:0][DW-1:0]      rd_k,
  output logic [PE_NUM-1:0][DW-1:0]      rd_v
);

  localparam int VW = PE_NUM * DW;

  state_t state, state_next;

  logic [PE_NUM-1:0][AW-1:0] acc_q_r, acc_k_r, acc_v_r;
  logic [4:0]                shift_r;
  logic [PE_NUM-1:0][DW-1:0] q_lane, k_lane, v_lane;
  logic [PE_NUM-1:0][DW-1:0] k_r, v_r;
  logic [VW-1:0]             k_ram [SEQ_LEN];
  logic [VW-1:0]             v_ram [SEQ_LEN];
  logic [VW-1:0]             rd_k_raw, rd_v_raw;
  logic                      accept;
  logic                      wr_en;

  assign full     = (tok_count == (IW + 1)'(SEQ_LEN));
  assign in_ready = (state == S_IDLE) && !full;
  assign accept   = in_valid && in_ready;
  assign q_valid  = (state == S_HOLDQ);
  assign wr_en    = (state == S_STORE) && !clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = S_QUANT;
      S_QUANT: state_next = S_STORE;
      S_STORE: state_next = S_HOLDQ;
      S_HOLDQ: if (q_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (clear) state_next = S_IDLE;
  end

  for (genvar i = 0; i < PE_NUM; i++) begin : g_lane
    requant_lane #(.AW(AW), .DW(DW)) u_q (.acc(acc_q_r[i]), .shift(shift_r), .q(q_lane[i]));
    requant_lane #(.AW(AW), .DW(DW)) u_k (.acc(acc_k_r[i]), .shift(shift_r), .q(k_lane[i]));
    requant_lane #(.AW(AW), .DW(DW)) u_v (.acc(acc_v_r[i]), .shift(shift_r), .q(v_lane[i]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q_r   <= '0;
      acc_k_r   <= '0;
      acc_v_r   <= '0;
      shift_r   <= '0;
      q_out     <= '0;
      k_r       <= '0;
      v_r       <= '0;
      tok_count <= '0;
    end else begin
      if (clear)      tok_count <= '0;
      else if (wr_en) tok_count <= tok_count + (IW + 1)'(1);
      if (accept) begin
        acc_q_r <= acc_q;
        acc_k_r <= acc_k;
        acc_v_r <= acc_v;
        shift_r <= cfg_shift;
      end
      if (state == S_QUANT) begin
        q_out <= q_lane;
        k_r   <= k_lane;
        v_r   <= v_lane;
      end
    end
  end

  // Cache contents survive reset and clear; visibility is governed only by tok_count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      k_ram[tok_count[IW-1:0]] <= k_r;
      v_ram[tok_count[IW-1:0]] <= v_r;
    end
    if (rd_en) begin
      rd_k_raw <= k_ram[rd_idx];
      rd_v_raw <= v_ram[rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      rd_err   <= rd_en && ({1'b0, rd_idx} >= tok_count);
    end
  end

  assign rd_k = (rd_valid && !rd_err) ? rd_k_raw : '0;
  assign rd_v = (rd_valid && !rd_err) ? rd_v_raw : '0;

endmodule
